push_arbiter: RTL
=================

Name: push_arbiter

Overview:
- Upstream stage of the scorer.
- Synchronises the left and right pushbuttons and runs each round: a random delay with the lights off, then lights on.
- Decides who pushed first and emits the scorer's inputs: a one-cycle winrnd pulse, right and leds_on.
- Freezes new rounds while game_over (a win state decoded from the score) is high.

Parameters:
- MIN_DELAY, 500: minimum lights-off delay, in tick periods.
- RAND_BITS, 10: number of LFSR bits added to MIN_DELAY as the random part of the delay.
- HOLD_TICKS, 1000: tick periods the result is held before the next round may begin.
- CNT_W, 12: width of the shared delay/hold counter. Must hold MIN_DELAY+2^RAND_BITS-1 and HOLD_TICKS.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- tick, input, 1: one-cycle timebase enable (nominally 1 kHz).
- pb_l, input, 1: left pushbutton, asynchronous, active high.
- pb_r, input, 1: right pushbutton, asynchronous, active high.
- game_over, input, 1: high while the score shows WL or WR.
- winrnd, output, 1: one-cycle pulse; a push has been judged.
- right, output, 1: 1 = right player pushed, 0 = left. Valid while winrnd=1; held until the next judgement.
- leds_on, output, 1: lights state. Its value in the winrnd cycle says whether the push was proper.
- busy, output, 1: high in ARM, LIT, JUDGE and HOLD.

Behaviour:
- Reset (rst sampled high on a clk edge):
  - state=IDLE; winrnd=0, right=0, leds_on=0, busy=0.
  - Synchroniser flops=0; counter=0; LFSR=LFSR_SEED; tie bit=0.
  - Reset mid-round abandons the round with no winrnd.
- Synchroniser:
  - Each button passes through s1→s2; s3 is the previous s2.
  - Push event: p_x = s2_x & ~s3_x, a rising edge only. A held button never re-triggers.
  - The button sampled high at edge n gives p_x=1 in cycle n+2.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every clk, including in IDLE.
- State machine:
  - IDLE: leds_on=0.
    - Both s2_l and s2_r at 0 and game_over=0 → ARM.
    - On that transition, counter = MIN_DELAY + LFSR[RAND_BITS-1:0].
  - ARM: leds_on=0; counter decrements on tick.
    - Any push event → JUDGE with the jump flag set.
    - Else, tick with counter==1 (or counter==0) → LIT; leds_on goes high the following cycle.
  - LIT: leds_on=1; waits indefinitely for a push event, then → JUDGE.
  - JUDGE, exactly one cycle:
    - winrnd=1, right=winner.
    - leds_on keeps its value from the push cycle: 0 if jumped, 1 if proper.
    - Next state → HOLD with counter=HOLD_TICKS.
  - HOLD: leds_on=0 from the first HOLD cycle; counter decrements on tick; at 0 → IDLE.
- Latency:
  - Push event in cycle k → winrnd high in cycle k+1, low in k+2.
  - Push pin to winrnd: 3 clocks.
- Winner:
  - Only p_l → right=0; only p_r → right=1.
  - p_l and p_r in the same cycle (tie):
    - right = tie bit, then the tie bit toggles.
    - The first tie after reset goes to left.
- Events in the same cycle:
  - A push in the same cycle as the ARM→LIT tick counts as a jump: push has priority, leds_on=0.
  - Pushes in JUDGE, HOLD or IDLE are ignored.
- game_over:
  - Sampled only in IDLE.
  - A round already in progress completes normally even if game_over rises mid-round.
- Outputs:
  - All outputs registered.
  - winrnd is never high on two consecutive cycles.

Test Plan (overrides: MIN_DELAY=2, RAND_BITS=2, HOLD_TICKS=3, tick=1 every cycle, LFSR_SEED=16'h0001):
- Reset, buttons low:
  - IDLE→ARM is seen, leds_on rises after 2..5 ticks, and busy=1.
  - No winrnd occurs without a push.
- Proper right push:
  - In LIT, pulse pb_r.
  - Required: winrnd=1 for exactly 1 cycle, 3 clocks after pb_r is sampled; right=1, leds_on=1 in that cycle.
  - Then HOLD for 3 ticks, then IDLE.
- Jump by left:
  - Pulse pb_l in ARM.
  - Required: winrnd=1, right=0, leds_on=0; the LIT state is never entered.
- Simultaneous pushes:
  - Both buttons rise together in LIT, twice across two rounds.
  - Required: first winrnd has right=0, second has right=1.
- Held button and game_over:
  - pb_r held high from IDLE → stays in IDLE until release.
  - game_over=1 in IDLE → stays in IDLE.
  - Deassert game_over → ARM next cycle.
- Reset mid-round:
  - Assert rst in LIT.
  - Required: next cycle state=IDLE with all outputs 0, and no winrnd pulse.

Source files
------------

// File: rtl/push_arbiter.sv
`timescale 1ns/1ps
// push_arbiter: upstream stage of the scorer. It synchronises the two
// pushbuttons and runs each round: a random lights-off delay, then lights on.
// It judges who pushed first and freezes new rounds while game_over is high.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   tick       one-cycle timebase enable (delay/hold counters step on it)
//   pb_l/pb_r  asynchronous pushbuttons, active high
//   game_over  high while the score shows a win; sampled only in IDLE
//   winrnd     one-cycle pulse when a push has been judged
//   right      winner (1 = right); held until the next judgement
//   leds_on    lights state; in the winrnd cycle, 1 = proper push, 0 = jump
//   busy       high while a round is in progress (ARM, LIT, JUDGE, HOLD)
module push_arbiter #(
  parameter int          MIN_DELAY  = 500,
  parameter int          RAND_BITS  = 10,
  parameter int          HOLD_TICKS = 1000,
  parameter int          CNT_W      = 12,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pb_l,
  input  logic pb_r,
  input  logic game_over,
  output logic winrnd,
  output logic right,
  output logic leds_on,
  output logic busy
);

  typedef enum logic [2:0] {IDLE, ARM, LIT, JUDGE, HOLD} state_t;

  state_t             state;
  logic [2:0]         sync_l, sync_r;  // [0]=s1, [1]=s2, [2]=s3 (previous s2)
  logic [CNT_W-1:0]   cnt;             // shared delay / hold counter
  logic [15:0]        lfsr;
  logic               tie;             // next tie goes to this side

  logic p_l, p_r, push, both, winner, at_end;

  // Rising edges of the synchronised buttons only; a held button is one event.
  assign p_l    = sync_l[1] & ~sync_l[2];
  assign p_r    = sync_r[1] & ~sync_r[2];
  assign push   = p_l | p_r;
  assign both   = p_l & p_r;
  assign winner = both ? tie : p_r;
  // Counter 0 is treated like 1 so a zero-length delay still terminates.
  assign at_end = tick && (cnt == '0 || cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sync_l  <= '0;
      sync_r  <= '0;
      cnt     <= '0;
      lfsr    <= LFSR_SEED;
      tie     <= 1'b0;
      winrnd  <= 1'b0;
      right   <= 1'b0;
      leds_on <= 1'b0;
      busy    <= 1'b0;
    end else begin
      sync_l <= {sync_l[1:0], pb_l};
      sync_r <= {sync_r[1:0], pb_r};
      // Fibonacci LFSR, taps 16,14,13,11; free-running so the delay depends
      // on how long the players sat in IDLE.
      lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      winrnd <= 1'b0;

      case (state)
        IDLE: begin
          leds_on <= 1'b0;
          // Both buttons must be released, so a held button cannot arm a round.
          if (!sync_l[1] && !sync_r[1] && !game_over) begin
            state <= ARM;
            busy  <= 1'b1;
            cnt   <= CNT_W'(MIN_DELAY) + CNT_W'(lfsr[RAND_BITS-1:0]);
          end
        end

        ARM, LIT: begin
          // A push wins over the lights-on tick: same-cycle push is a jump.
          // leds_on is left alone so it records jump (0) or proper (1).
          if (push) begin
            state  <= JUDGE;
            winrnd <= 1'b1;
            right  <= winner;
            if (both) tie <= ~tie;
          end else if (state == ARM && tick) begin
            if (at_end) begin
              state   <= LIT;
              leds_on <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end

        JUDGE: begin
          state   <= HOLD;
          leds_on <= 1'b0;
          cnt     <= CNT_W'(HOLD_TICKS);
        end

        HOLD: begin
          if (tick) begin
            if (at_end) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
